pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 tb/tb_pipe_skid_reg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_reg
//  Purpose  : Two-entry pipeline skid register with hold/clear control and an
//             optional back-pressure cycle counter (macro PIPE_SKID_PERF_EN).
//  Revision : 1.0  initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int              DW      = 32,
    parameter logic [DW-1:0]   CLR_VAL = {DW{1'b0}}
) (
    input  logic            clk_100M,
    input  logic            arst_n,
    input  logic            clear,
    input  logic            hold,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      level,
    output logic [15:0]     stall_cnt
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_head;
    logic [DW-1:0]   r_skid;
    logic            w_push;
    logic            w_pop;

    // in_ready is built from registered state and hold only, never out_ready.
    assign in_ready  = (r_state != ST_FULL) && !hold;
    assign out_valid = (r_state != ST_EMPTY) && !hold;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_head;
    assign level     = r_state;

    always_ff @(posedge clk_100M or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= CLR_VAL;
            r_skid  <= CLR_VAL;
        end else if (clear) begin
            r_state <= ST_EMPTY;
            r_head  <= CLR_VAL;
            r_skid  <= CLR_VAL;
        end else if (!hold) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_head  <= in_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= in_data;
                    end else if (w_push) begin
                        r_skid  <= in_data;
                        r_state <= ST_FULL;
                    end else if (w_pop) begin
                        r_head  <= CLR_VAL;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_skid;
                        r_skid  <= CLR_VAL;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_head  <= CLR_VAL;
                    r_skid  <= CLR_VAL;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    // Saturating stall counter; only the asynchronous reset clears it.
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_100M or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// Directed and randomized-scoreboard bench for pipe_skid_reg (DW=32).
module tb_pipe_skid_reg;

    localparam int DW = 32;

    logic            clk_100M = 1'b0;
    logic            arst_n;
    logic            clear;
    logic            hold;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      level;
    logic [15:0]     stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pipe_skid_reg #(.DW(DW)) dut (
        .clk_100M  (clk_100M),
        .arst_n    (arst_n),
        .clear     (clear),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .stall_cnt (stall_cnt)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic cyc();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; clear = 1'b0; hold = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_total++; if (level !== 2'd0) $display("FAIL rst_level: got %0d expected 0", level); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL rst_out_data: got %h expected 00000000", out_data); else n_pass++;
        n_total++; if (stall_cnt !== 16'h0) $display("FAIL rst_stall_cnt: got %h expected 0000", stall_cnt); else n_pass++;
        cyc();
        arst_n = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 32'h0000_0013; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b expected 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 32'h0000_0013) $display("FAIL single_out_data: got %h expected 00000013", out_data); else n_pass++;
        n_total++; if (level !== 2'd1) $display("FAIL single_level: got %0d expected 1", level); else n_pass++;
        cyc();
        n_total++; if (level !== 2'd0) $display("FAIL single_drain_level: got %0d expected 0", level); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL single_drain_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL single_empty_data: got %h expected 00000000", out_data); else n_pass++;
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_000A;
        cyc();
        in_data = 32'h0000_000B;
        cyc();
        in_valid = 1'b0;
        n_total++; if (level !== 2'd2) $display("FAIL fill_level: got %0d expected 2", level); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", in_ready); else n_pass++;
        n_total++; if (out_data !== 32'h0000_000A) $display("FAIL fill_head: got %h expected 0000000a", out_data); else n_pass++;
        out_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL full_ready_indep: got %b expected 0", in_ready); else n_pass++;
        cyc();
        n_total++; if (out_data !== 32'h0000_000B) $display("FAIL drain_second: got %h expected 0000000b", out_data); else n_pass++;
        n_total++; if (level !== 2'd1) $display("FAIL drain_level1: got %0d expected 1", level); else n_pass++;
        cyc();
        n_total++; if (level !== 2'd0) $display("FAIL drain_level0: got %0d expected 0", level); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL drain_valid: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_00C0;
        cyc();
        in_data = 32'h0000_00D0;
        cyc();
        in_data = 32'h0000_00E0; hold = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_total++; if (out_valid !== 1'b0) $display("FAIL hold_out_valid[%0d]: got %b expected 0", i, out_valid); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); else n_pass++;
            n_total++; if (level !== 2'd2) $display("FAIL hold_level[%0d]: got %0d expected 2", i, level); else n_pass++;
        end
        hold = 1'b0; in_valid = 1'b0;
        #1;
        n_total++; if (out_data !== 32'h0000_00C0) $display("FAIL hold_head: got %h expected 000000c0", out_data); else n_pass++;
        cyc();
        n_total++; if (out_data !== 32'h0000_00D0) $display("FAIL hold_skid: got %h expected 000000d0", out_data); else n_pass++;
        cyc();
        n_total++; if (level !== 2'd0) $display("FAIL hold_drain_level: got %0d expected 0", level); else n_pass++;
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0001;
        cyc();
        in_data = 32'h0000_0002;
        cyc();
        clear = 1'b1; hold = 1'b1; in_data = 32'h0000_0003;
        cyc();
        clear = 1'b0; hold = 1'b0; in_valid = 1'b0;
        #1;
        n_total++; if (level !== 2'd0) $display("FAIL clear_level: got %0d expected 0", level); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL clear_data: got %h expected 00000000", out_data); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL clear_valid: got %b expected 0", out_valid); else n_pass++;
        in_valid = 1'b1; in_data = 32'h0000_0004;
        cyc();
        in_data = 32'h0000_0005;
        cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        n_total++; if (out_data !== 32'h0000_0004) $display("FAIL clear_refill_head: got %h expected 00000004", out_data); else n_pass++;
        cyc();
        n_total++; if (out_data !== 32'h0000_0005) $display("FAIL clear_refill_skid: got %h expected 00000005", out_data); else n_pass++;
        cyc();
        n_total++; if (level !== 2'd0) $display("FAIL clear_drain_level: got %0d expected 0", level); else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'h0000_0100 + 32'(i);
            cyc();
            n_total++; if (out_data !== 32'h0000_0100 + 32'(i)) $display("FAIL b2b_data[%0d]: got %h expected %h", i, out_data, 32'h0000_0100 + 32'(i)); else n_pass++;
            n_total++; if (level !== 2'd1) $display("FAIL b2b_level[%0d]: got %0d expected 1", i, level); else n_pass++;
        end
        out_ready = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL one_ready_indep: got %b expected 1", in_ready); else n_pass++;
        out_ready = 1'b1; in_valid = 1'b0;
        cyc();
        n_total++; if (level !== 2'd0) $display("FAIL b2b_drain_level: got %0d expected 0", level); else n_pass++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0077;
        cyc();
        in_valid = 1'b0;
        n_total++; if (level !== 2'd1) $display("FAIL arst_pre_level: got %0d expected 1", level); else n_pass++;
        #2 arst_n = 1'b0;
        #1;
        n_total++; if (level !== 2'd0) $display("FAIL arst_level: got %0d expected 0", level); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL arst_data: got %h expected 00000000", out_data); else n_pass++;
        #1 arst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'h0000_0099;
        cyc();
        in_valid = 1'b0;
        n_total++; if (level !== 2'd1) $display("FAIL arst_first_push_level: got %0d expected 1", level); else n_pass++;
        n_total++; if (out_data !== 32'h0000_0099) $display("FAIL arst_first_push_data: got %h expected 00000099", out_data); else n_pass++;
        out_ready = 1'b1;
        cyc();
    endtask

    task automatic test_stall_cnt();
        logic [15:0] exp_cnt;
        #2 arst_n = 1'b0;
        #1 arst_n = 1'b1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0055;
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        hold = 1'b1;
        repeat (3) cyc();
        hold = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0;
`ifdef PIPE_SKID_PERF_EN
        exp_cnt = 16'd5;
`else
        exp_cnt = 16'd0;
`endif
        n_total++; if (stall_cnt !== exp_cnt) $display("FAIL stall_count: got %h expected %h", stall_cnt, exp_cnt); else n_pass++;
`ifdef PIPE_SKID_PERF_EN
        in_valid = 1'b1; in_data = 32'h0000_0066;
        cyc();
        in_valid = 1'b0;
        repeat (70000) cyc();
        n_total++; if (stall_cnt !== 16'hFFFF) $display("FAIL stall_saturate: got %h expected ffff", stall_cnt); else n_pass++;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        n_total++; if (stall_cnt !== 16'hFFFF) $display("FAIL stall_clear_immune: got %h expected ffff", stall_cnt); else n_pass++;
`endif
        out_ready = 1'b1;
        cyc();
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic          exp_push;
        logic          exp_pop;
        int            sz;
        q.delete();
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            #1;
            sz = q.size();
            n_total++; if (level !== 2'(sz)) $display("FAIL rnd_level[%0d]: got %0d expected %0d", i, level, sz); else n_pass++;
            n_total++; if (in_ready !== (sz < 2)) $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, (sz < 2)); else n_pass++;
            n_total++; if (out_valid !== (sz > 0)) $display("FAIL rnd_out_valid[%0d]: got %b expected %b", i, out_valid, (sz > 0)); else n_pass++;
            exp_push = in_valid && (sz < 2);
            exp_pop  = out_ready && (sz > 0);
            if (exp_pop) begin
                n_total++; if (out_data !== q[0]) $display("FAIL rnd_order[%0d]: got %h expected %h", i, out_data, q[0]); else n_pass++;
                void'(q.pop_front());
            end
            if (exp_push) q.push_back(in_data);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_hold();
        test_clear();
        test_back_to_back();
        test_async_reset();
        test_stall_cnt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
